tile_mem_arbiter: RTL and testbench
===================================

# tile_mem_arbiter

Two-to-one OBI arbiter that shares a single memory port between the cv32e40p instruction fetch interface and data interface inside the tile. Round-robin arbitration with request locking keeps the shared port OBI-compliant. An in-order owner FIFO tracks up to MAX_OUTSTANDING accepted transactions and routes each response back to the master that issued it. Sits between u_rv_core and the tile's single memory/interconnect port.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width; BE width is DATA_W/8
- MAX_OUTSTANDING, 2, owner FIFO depth (≥1); max accepted-but-unanswered transactions
- core_clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1  instruction OBI handshake
- instr_addr_i  in  ADDR_W  fetch address
- instr_rdata_o  out  DATA_W  fetch read data
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  data OBI handshake
- data_we_i  in  1  write enable
- data_be_i  in  DATA_W/8  byte enables
- data_addr_i  in  ADDR_W  data address
- data_wdata_i  in  DATA_W  write data
- data_rdata_o  out  DATA_W  data read data
- mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1  shared-port OBI handshake
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  shared-port request fields
- mem_rdata_i  in  DATA_W  shared-port read data
- proto_err_o  out  1  sticky: mem_rvalid_i seen with no transaction outstanding

## Operation

- sel: selected master (INSTR/DATA), combinational from req inputs, last-granted pointer, lock.
- Unlocked: only one req → that master; both → master ≠ last granted; neither → hold previous sel, mem_req_o=0.
- mem_req_o = req of sel AND NOT fifo_full. Request fields muxed from sel; instr requests drive mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- Lock: registered flag set when mem_req_o=1 and mem_gnt_i=0; cleared on handshake or if locked master drops req. While locked, sel is frozen (address/fields stable until gnt per OBI).
- Grants: instr_gnt_o = mem_gnt_i & mem_req_o & sel==INSTR; data likewise. Never both.
- Handshake (mem_req_o & mem_gnt_i): push sel into owner FIFO; last-granted ← sel.
- Response: on mem_rvalid_i with FIFO non-empty, pop head; rvalid raised only toward head owner. mem_rdata_i broadcast to both rdata outputs unqualified.
- mem_rvalid_i with FIFO empty: ignored (no pop, no rvalid out), proto_err_o set until reset.
- Push and pop same cycle: count unchanged, pointers both advance.
- fifo_full (count==MAX_OUTSTANDING) masks mem_req_o; lock is not set while masked; pop same cycle does not unmask (uses registered count).

## Timing

- Reset values: mem_req_o=0, all gnt/rvalid outputs=0, proto_err_o=0, FIFO empty, lock=0, last-granted=DATA (INSTR wins first contention).
- req→mem_req_o, mem_gnt_i→*_gnt_o, mem_rvalid_i→*_rvalid_o: combinational, zero added latency.
- Transaction latency = slave latency; arbiter adds no cycles. Back-to-back grants every cycle sustained while FIFO not full.
- Slave must not return rvalid in the grant cycle (OBI); response for a handshake in cycle N earliest in N+1.
- Responses strictly in order; owner FIFO order = grant order.
- Reset mid-operation: FIFO, lock, pointer, proto_err_o cleared immediately (async); in-flight responses are discarded—slave is reset by the same arst_n.

## Test plan

- Single fetch: instr_req_i=1 addr 0x100, gnt in cycle 1, rvalid cycle 3 rdata 0xDEADBEEF → instr_rvalid_o=1 with 0xDEADBEEF in cycle 3, data_rvalid_o=0 throughout.
- Contention from reset: both req every cycle, gnt always 1 → grants alternate INSTR, DATA, INSTR, DATA; mem_we_o=0 on instr beats, data fields on data beats.
- Lock: both req, mem_gnt_i=0 for 3 cycles → sel and mem_addr_o stable all 3 cycles; gnt in cycle 4 goes to originally selected master only.
- Outstanding limit (MAX_OUTSTANDING=2): 2 grants, no rvalid → mem_req_o=0 third cycle; one rvalid → mem_req_o=1 next cycle; responses routed INSTR then DATA matching grant order.
- Spurious response: mem_rvalid_i=1 with FIFO empty → no rvalid outputs, proto_err_o=1 next cycle and held; deassert arst_n → proto_err_o=0.
- Mid-flight reset: 2 outstanding, pulse arst_n low → FIFO empty, mem_req_o=0; after release both req → INSTR granted first.

Source files
------------

// File: rtl/tile_mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory OBI signals around the tile arbiter.
// Latency: none; wires only.
// Backpressure: carries gnt back to both masters and req/fields forward to the memory port.
interface tile_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // instruction fetch side
  logic              instr_req_i;
  logic              instr_gnt_o;
  logic              instr_rvalid_o;
  logic [ADDR_W-1:0] instr_addr_i;
  logic [DATA_W-1:0] instr_rdata_o;
  // data side
  logic                instr_unused_dummy_n;
  logic                data_req_i;
  logic                data_gnt_o;
  logic                data_rvalid_o;
  logic                data_we_i;
  logic [DATA_W/8-1:0] data_be_i;
  logic [ADDR_W-1:0]   data_addr_i;
  logic [DATA_W-1:0]   data_wdata_i;
  logic [DATA_W-1:0]   data_rdata_o;
  // shared memory port
  logic                mem_req_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                proto_err_o;

  // arbiter view
  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output proto_err_o
  );

  // surrounding view: core masters plus memory slave
  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  proto_err_o
  );
endinterface

// File: rtl/tile_mem_arbiter.sv
// Round-robin 2:1 OBI arbiter (fetch vs data) with request lock and in-order owner FIFO.
// Latency: zero added cycles; req/gnt/rvalid paths are combinational.
// Backpressure: mem_gnt_i passed to the selected master; mem_req_o masked when owner FIFO full.
module tile_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic              core_clk,
  input logic              arst_n,
  tile_mem_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

  owner_e             sel;
  owner_e             sel_q, sel_d;
  owner_e             last_q, last_d;
  logic               lock_q, lock_d;
  logic               proto_err_q, proto_err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  owner_e             owner_q [MAX_OUTSTANDING];

  logic   fifo_full, fifo_empty;
  logic   sel_req, mem_req, handshake, pop;
  owner_e head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = owner_q[rd_ptr_q];

  // master selection: frozen while locked, otherwise round-robin on contention
  always_comb begin
    sel = sel_q;
    if (!lock_q) begin
      if (bus.instr_req_i && !bus.data_req_i)
        sel = OWN_INSTR;
      else if (!bus.instr_req_i && bus.data_req_i)
        sel = OWN_DATA;
      else if (bus.instr_req_i && bus.data_req_i)
        sel = (last_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end
  end

  assign sel_req   = (sel == OWN_DATA) ? bus.data_req_i : bus.instr_req_i;
  // full check uses the registered count, so a same-cycle pop cannot unmask
  assign mem_req   = sel_req & ~fifo_full;
  assign handshake = mem_req & bus.mem_gnt_i;
  // responses with nothing outstanding are dropped and only flagged
  assign pop       = bus.mem_rvalid_i & ~fifo_empty;

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = (sel == OWN_DATA) ? bus.data_we_i    : 1'b0;
  assign bus.mem_be_o    = (sel == OWN_DATA) ? bus.data_be_i    : '1;
  assign bus.mem_addr_o  = (sel == OWN_DATA) ? bus.data_addr_i  : bus.instr_addr_i;
  assign bus.mem_wdata_o = (sel == OWN_DATA) ? bus.data_wdata_i : '0;

  assign bus.instr_gnt_o    = handshake & (sel == OWN_INSTR);
  assign bus.data_gnt_o     = handshake & (sel == OWN_DATA);
  assign bus.instr_rvalid_o = pop & (head == OWN_INSTR);
  assign bus.data_rvalid_o  = pop & (head == OWN_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign bus.proto_err_o    = proto_err_q;

  // next-state for arbitration state and owner FIFO bookkeeping
  always_comb begin
    sel_d       = sel;
    last_d      = handshake ? sel : last_q;
    // a stalled request holds the lock; handshake or a dropped req releases it
    lock_d      = mem_req & ~bus.mem_gnt_i;
    proto_err_d = proto_err_q | (bus.mem_rvalid_i & fifo_empty);
    wr_ptr_d    = handshake ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    if (handshake && !pop)
      count_d = count_q + CNT_W'(1);
    else if (!handshake && pop)
      count_d = count_q - CNT_W'(1);
  end

  // control registers, cleared asynchronously
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      sel_q       <= OWN_INSTR;
      last_q      <= OWN_DATA;
      lock_q      <= 1'b0;
      proto_err_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      sel_q       <= sel_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      proto_err_q <= proto_err_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // owner storage; entries are only read while valid, so no reset needed
  always_ff @(posedge core_clk) begin
    if (handshake)
      owner_q[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Directed, table-driven bench for tile_mem_arbiter with MAX_OUTSTANDING=2.
// Latency: inputs driven at the falling edge, outputs checked 1ns later.
// Backpressure: mem_gnt_i/mem_rvalid_i scripted per vector.
module tb_tile_mem_arbiter;

  localparam logic [31:0] I_ADDR = 32'h0000_0100;
  localparam logic [31:0] D_ADDR = 32'h0000_2000;
  localparam logic [31:0] D_WDAT = 32'h55AA_1234;
  localparam logic [3:0]  D_BE   = 4'h3;

  logic core_clk;
  logic arst_n;
  int   n_chk;
  int   n_fail;

  tile_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  tile_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .bus      (bus)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic        gnt;
    logic        rvld;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_sel;   // 0 = instr fields on the bus, 1 = data fields
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ireq, dreq, dwe, gnt, rvld,
                              input logic [31:0] rdata,
                              input logic e_req, e_sel, e_ig, e_dg, e_irv, e_drv);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.gnt = gnt;
    v.rvld = rvld; v.rdata = rdata; v.e_req = e_req; v.e_sel = e_sel;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, dreq, dwe, gnt, rvld, input logic [31:0] rdata);
    bus.instr_req_i  = ireq;
    bus.instr_addr_i = I_ADDR;
    bus.data_req_i   = dreq;
    bus.data_we_i    = dwe;
    bus.data_be_i    = D_BE;
    bus.data_addr_i  = D_ADDR;
    bus.data_wdata_i = D_WDAT;
    bus.mem_gnt_i    = gnt;
    bus.mem_rvalid_i = rvld;
    bus.mem_rdata_i  = rdata;
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    #1;
    arst_n = 1'b1;
  endtask

  // control outputs only (handshake and error)
  task automatic chk_ctl(input string tag, input logic req, ig, dg, irv, drv, perr);
    chk({tag, " mem_req"},     {31'd0, bus.mem_req_o},     {31'd0, req});
    chk({tag, " instr_gnt"},   {31'd0, bus.instr_gnt_o},   {31'd0, ig});
    chk({tag, " data_gnt"},    {31'd0, bus.data_gnt_o},    {31'd0, dg});
    chk({tag, " instr_rvalid"},{31'd0, bus.instr_rvalid_o},{31'd0, irv});
    chk({tag, " data_rvalid"}, {31'd0, bus.data_rvalid_o}, {31'd0, drv});
    chk({tag, " proto_err"},   {31'd0, bus.proto_err_o},   {31'd0, perr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    arst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);

    // reset state
    @(negedge core_clk);
    @(negedge core_clk);
    #1;
    chk_ctl("reset", 0, 0, 0, 0, 0, 0);
    arst_n = 1'b1;

    // rst ireq dreq dwe gnt rvld rdata | req sel ig dg irv drv
    // single fetch
    vecs.push_back(mk(1,0,0,0,0,0,32'h0000_0000, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,0,32'h1111_0000, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0000_0002, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hDEAD_BEEF, 0,0,0,0,1,0));
    // contention from reset with a response every cycle
    vecs.push_back(mk(1,1,1,1,1,0,32'h0000_0003, 1,0,1,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,32'hA1A1_A1A1, 1,1,0,1,1,0));
    vecs.push_back(mk(0,1,1,0,1,1,32'hA2A2_A2A2, 1,0,1,0,0,1));
    vecs.push_back(mk(0,1,1,0,1,1,32'hA3A3_A3A3, 1,1,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hA4A4_A4A4, 0,1,0,0,0,1));
    // lock: data alone stalls, then instr joins but data keeps the port
    vecs.push_back(mk(0,0,1,1,0,0,32'h0000_0005, 1,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0000_0006, 1,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,32'h0000_0007, 1,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,32'h0000_0008, 1,1,0,1,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,32'h0000_0009, 1,0,1,0,0,0));
    // outstanding limit: full masks, same-cycle pop does not unmask
    vecs.push_back(mk(0,1,1,1,1,0,32'h0000_000A, 0,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,1,32'hB0B0_0011, 0,1,0,0,0,1));
    vecs.push_back(mk(0,1,1,1,1,0,32'h0000_0012, 1,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hC0C0_0013, 0,1,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,32'hC0C0_0014, 0,1,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,32'h0000_0015, 0,1,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      vec_t  v;
      v   = vecs[i];
      tag = $sformatf("v%0d", i);
      @(negedge core_clk);
      if (v.rst) pulse_reset();
      drive(v.ireq, v.dreq, v.dwe, v.gnt, v.rvld, v.rdata);
      #1;
      chk_ctl(tag, v.e_req, v.e_ig, v.e_dg, v.e_irv, v.e_drv, 0);
      chk({tag, " mem_addr"},  bus.mem_addr_o,  v.e_sel ? D_ADDR : I_ADDR);
      chk({tag, " mem_we"},    {31'd0, bus.mem_we_o}, {31'd0, v.e_sel ? v.dwe : 1'b0});
      chk({tag, " mem_be"},    {28'd0, bus.mem_be_o}, {28'd0, v.e_sel ? D_BE : 4'hF});
      chk({tag, " mem_wdata"}, bus.mem_wdata_o, v.e_sel ? D_WDAT : 32'h0);
      chk({tag, " instr_rdata"}, bus.instr_rdata_o, v.rdata);
      chk({tag, " data_rdata"},  bus.data_rdata_o,  v.rdata);
    end

    // spurious response: dropped, error sticky until reset
    @(negedge core_clk);
    pulse_reset();
    drive(0, 0, 0, 0, 1, 32'h5555_5555);
    #1;
    chk_ctl("spur0", 0, 0, 0, 0, 0, 0);
    @(negedge core_clk);
    drive(0, 0, 0, 0, 0, 32'h0);
    #1;
    chk_ctl("spur1", 0, 0, 0, 0, 0, 1);
    @(negedge core_clk);
    #1;
    chk_ctl("spur2", 0, 0, 0, 0, 0, 1);
    arst_n = 1'b0;
    #1;
    chk_ctl("spur_rst", 0, 0, 0, 0, 0, 0);
    arst_n = 1'b1;

    // mid-flight reset with two outstanding
    @(negedge core_clk);
    drive(1, 1, 0, 1, 0, 32'h0);
    #1;
    chk_ctl("mf_g0", 1, 1, 0, 0, 0, 0);
    @(negedge core_clk);
    #1;
    chk_ctl("mf_g1", 1, 0, 1, 0, 0, 0);
    @(negedge core_clk);
    #1;
    chk_ctl("mf_full", 0, 0, 0, 0, 0, 0);
    @(negedge core_clk);
    drive(0, 0, 0, 0, 0, 32'h0);
    arst_n = 1'b0;
    #1;
    chk_ctl("mf_inrst", 0, 0, 0, 0, 0, 0);
    arst_n = 1'b1;
    @(negedge core_clk);
    drive(1, 1, 0, 1, 0, 32'h0);
    #1;
    chk_ctl("mf_a0", 1, 1, 0, 0, 0, 0);
    @(negedge core_clk);
    #1;
    chk_ctl("mf_a1", 1, 0, 1, 0, 0, 0);
    @(negedge core_clk);
    #1;
    chk_ctl("mf_a2", 0, 0, 0, 0, 0, 0);

    @(negedge core_clk);
    drive(0, 0, 0, 0, 0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
